instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Fetch-side producer for the decode stage.
- Holds the program counter, issues single-outstanding requests to instruction memory, and presents each fetched word with its PC to the instruction field-extraction mux.
- Drives that mux's flush input whenever no valid instruction is present, or the pipeline is redirected, so decode sees a NOP (32'h0000_0013).
- Handles decode-stage stall, branch/jump/trap redirects and misaligned redirect targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- TRAP_PC, 32'h0000_0100, fetch target used when a redirect target is misaligned

Ports:
- clk_in  input  1  single clock, all state on rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- stall_in  input  1  decode stage cannot accept a new instruction this cycle
- redirect_in  input  1  branch/jump/trap taken; one-cycle pulse
- redirect_pc_in  input  32  redirect target
- imem_req_out  output  1  fetch request (combinational)
- imem_addr_out  output  32  fetch address, equals internal pc_reg
- imem_ready_in  input  1  memory returns data this cycle for the current request
- imem_rdata_in  input  32  fetched word, valid when imem_req_out & imem_ready_in
- instr_out  output  32  instruction to decode mux (registered)
- pc_out  output  32  PC of instr_out (registered)
- instr_valid_out  output  1  instr_out holds a real fetched instruction
- flush_out  output  1  to decode mux flush input; always equals ~instr_valid_out
- misaligned_out  output  1  one-cycle pulse: redirect target had [1:0] != 0

## Operation
- State machine with three states:
  - IDLE: entered on reset, lasts exactly one cycle, no request; always goes to RUN.
  - RUN: normal fetching.
  - REDIR: one bubble cycle after a redirect, no request; always goes to RUN.
- Acceptance: accept = ~stall_in | ~instr_valid_out.
- Request: imem_req_out = (state==RUN) & accept & ~redirect_in. Address held stable while req is high and ready is low.
- Handshake (req & ready): instr_out<=imem_rdata_in, pc_out<=pc_reg, instr_valid_out<=1, pc_reg<=pc_reg+4.
- Stall: stall_in & instr_valid_out with no redirect: instr_out, pc_out and instr_valid_out are held.
- No handshake and accept true (no redirect): instr_out<=32'h13, instr_valid_out<=0, pc_out held.
- Redirect has highest priority over stall, handshake and state:
  - next state is REDIR; instr_out<=32'h13; instr_valid_out<=0.
  - pc_reg<=redirect_pc_in if redirect_pc_in[1:0]==0; otherwise pc_reg<=TRAP_PC and misaligned_out<=1 for one cycle.
  - Any memory data in the redirect cycle is discarded (req is forced low).
- redirect_in in IDLE or REDIR is honoured identically; a REDIR cycle is retaken.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Bits [1:0] are always 0.

## Timing
- Reset values (async, while rst_n_in low):
  - state=IDLE, pc_reg=RESET_PC, pc_out=RESET_PC
  - instr_out=32'h13, instr_valid_out=0, flush_out=1, misaligned_out=0
  - imem_req_out=0
- First request appears in the second rising edge's cycle after reset release (IDLE occupies one cycle).
- Fetch latency: data accepted at edge N appears on instr_out/pc_out after edge N.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Redirect at edge N:
  - bubble visible after N (flush_out=1).
  - REDIR occupies cycle N..N+1.
  - First request to the target is issued in the cycle after edge N+1.
- Reset asserted mid-request: outputs are cleared immediately. The memory must tolerate req dropping without ready.

## Test plan
- Reset release, RESET_PC=0, ready tied 1, rdata=addr|32'h13:
  - imem_addr_out sequence 0,4,8,C, one per cycle after IDLE.
  - instr_out/pc_out follow one cycle later.
  - flush_out=0 from the first valid word.
- stall_in held 3 cycles with instr_valid_out=1:
  - imem_req_out=0; instr_out, pc_out and imem_addr_out frozen.
  - On release, fetch resumes at the next sequential PC with no word lost or duplicated.
- redirect_in with target 32'h0000_0200 while stalled:
  - next cycle instr_out=32'h13, flush_out=1, instr_valid_out=0.
  - one REDIR cycle with req=0, then imem_addr_out=32'h200.
- redirect target 32'h0000_0202:
  - misaligned_out high exactly one cycle.
  - next request address equals TRAP_PC (32'h100).
- imem_ready_in low for 2 cycles during a request:
  - req stays 1 and address stable.
  - instr_out=32'h13 with flush_out=1 during the wait.
  - word captured on the cycle ready=1.
- RESET_PC=32'hFFFF_FFFC: addresses FFFF_FFFC then 0000_0000.
- rst_n_in pulsed low mid-stream: all outputs return to reset values immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request at a time,
// and hands each fetched word plus its PC to the decode mux.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out,
  output logic        misaligned_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REDIR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_reg;
  logic        accept;
  logic        hs;
  logic        target_ok;

  assign accept        = ~stall_in | ~instr_valid_out;
  assign imem_req_out  = (state == RUN) & accept & ~redirect_in;
  assign hs            = imem_req_out & imem_ready_in;
  assign imem_addr_out = pc_reg;
  assign flush_out     = ~instr_valid_out;
  assign target_ok     = (redirect_pc_in[1:0] == 2'b00);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_in) begin
      state_nxt = REDIR;
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = RUN;
        REDIR:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Redirect beats stall and any in-flight data (req is already forced low)
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_reg          <= RESET_PC;
      pc_out          <= RESET_PC;
      instr_out       <= NOP;
      instr_valid_out <= 1'b0;
      misaligned_out  <= 1'b0;
    end else if (redirect_in) begin
      instr_out       <= NOP;
      instr_valid_out <= 1'b0;
      misaligned_out  <= ~target_ok;
      pc_reg          <= target_ok ? redirect_pc_in : TRAP_PC;
    end else begin
      misaligned_out <= 1'b0;
      if (hs) begin
        instr_out       <= imem_rdata_in;
        pc_out          <= pc_reg;
        instr_valid_out <= 1'b1;
        pc_reg          <= pc_reg + 32'd4;
      end else if (accept) begin
        instr_out       <= NOP;
        instr_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a cycle-level
// behavioural model of the fetch rules.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        req;
  logic [31:0] addr;
  logic        ready = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        flush;
  logic        mis;

  logic        hi_req;
  logic [31:0] hi_addr;
  logic [31:0] hi_instr;
  logic [31:0] hi_pc;
  logic        hi_valid;
  logic        hi_flush;
  logic        hi_mis;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  bit          m_valid;
  bit          m_mis;
  bit          m_blocked;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .stall_in        (stall),
    .redirect_in     (redir),
    .redirect_pc_in  (redir_pc),
    .imem_req_out    (req),
    .imem_addr_out   (addr),
    .imem_ready_in   (ready),
    .imem_rdata_in   (rdata),
    .instr_out       (instr),
    .pc_out          (pc),
    .instr_valid_out (valid),
    .flush_out       (flush),
    .misaligned_out  (mis)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .stall_in        (1'b0),
    .redirect_in     (1'b0),
    .redirect_pc_in  (32'h0),
    .imem_req_out    (hi_req),
    .imem_addr_out   (hi_addr),
    .imem_ready_in   (1'b1),
    .imem_rdata_in   (hi_addr | 32'h13),
    .instr_out       (hi_instr),
    .pc_out          (hi_pc),
    .instr_valid_out (hi_valid),
    .flush_out       (hi_flush),
    .misaligned_out  (hi_mis)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a | 32'h13;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RPC;
    m_pcout   = RPC;
    m_instr   = NOP;
    m_valid   = 0;
    m_mis     = 0;
    m_blocked = 1;
  endtask

  task automatic check_regs();
    check("instr", instr, m_instr);
    check("pc_out", pc, m_pcout);
    check("valid", {31'b0, valid}, {31'b0, m_valid});
    check("flush", {31'b0, flush}, {31'b0, !m_valid});
    check("misaligned", {31'b0, mis}, {31'b0, m_mis});
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input bit s, input bit r, input logic [31:0] t,
                       input bit rdy);
    bit acc;
    bit exp_req;
    check_regs();
    stall    = s;
    redir    = r;
    redir_pc = t;
    ready    = rdy;
    rdata    = mem(m_pc);
    #1;
    acc     = !s || !m_valid;
    exp_req = !m_blocked && acc && !r;
    check("req", {31'b0, req}, {31'b0, exp_req});
    check("addr", addr, m_pc);
    if (r) begin
      m_blocked = 1;
      m_instr   = NOP;
      m_valid   = 0;
      m_mis     = (t[1:0] != 2'b00);
      m_pc      = m_mis ? TRAP : t;
    end else begin
      m_blocked = 0;
      m_mis     = 0;
      if (exp_req && rdy) begin
        m_instr = mem(m_pc);
        m_pcout = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
      end else if (acc) begin
        m_instr = NOP;
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] hi_exp [3];
    logic [31:0] tgt;
    hi_exp[0] = 32'hFFFF_FFFC;
    hi_exp[1] = 32'hFFFF_FFFC;
    hi_exp[2] = 32'h0000_0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_regs();
    check("rst_req", {31'b0, req}, 32'h0);
    rst_n = 1'b1;

    // sequential fetch, zero-wait memory
    for (int i = 0; i < 6; i++) begin
      if (i < 3) check("hi_addr", hi_addr, hi_exp[i]);
      if (i == 1) check("hi_req", {31'b0, hi_req}, 32'h1);
      cycle(0, 0, 0, 1);
    end
    // stall 3 cycles, then resume
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    // redirect while stalled
    cycle(1, 1, 32'h0000_0200, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    // misaligned redirect
    cycle(0, 1, 32'h0000_0202, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    // memory wait states
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    // back-to-back redirect retakes REDIR
    cycle(0, 1, 32'h0000_0400, 1);
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt,
            $urandom_range(0, 9) < 7);
    end

    // asynchronous reset mid-stream
    stall = 1'b0;
    redir = 1'b0;
    ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    check("rst_req", {31'b0, req}, 32'h0);
    check("rst_addr", addr, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
